// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
// Holds length-field sizing, reset-default pattern and mode encodings.
// No logic; imported by the window and top modules.
package seq_det_pkg;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Pattern 101111, right-aligned, loaded at reset.
  localparam logic [7:0] DEF_PATTERN_C = 8'b0010_1111;
  localparam int         DEF_LEN_C     = 6;

  // Overlap mode encodings.
  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

  // Output timing encodings.
  localparam logic OUT_MEALY = 1'b0;
  localparam logic OUT_MOORE = 1'b1;

endpackage

// File: rtl/seq_det_window.sv
// History window of the most recent stream bits, with fill tracking and masked pattern compare.
// hit_o is combinational in the cycle of the final pattern bit; state updates on the next edge.
// No backpressure: invalid cycles hold state, clear_i wipes history and masks hit_o.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  input  logic               x_i,
  input  logic               clear_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               hit_o
);

  // Only MAX_LEN-1 past bits are needed: the current bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // Build the newest-at-bit-0 window and the low-len mask, then compare.
  always_comb begin
    window = {hist_q, x_i};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_i);
    end
    hit_o = in_valid_i && !clear_i && (len_i != '0) &&
            (fill_q >= len_i - LEN_W'(1)) &&
            ((window & mask) == (pattern_i & mask));
  end

  // Shift in valid bits; fill restarts after a hit when matches may not overlap.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = window[MAX_LEN-2:0];
      if (hit_o && (overlap_i == OVL_OFF)) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// z: 0 cycles after final bit (Mealy) or 1 cycle (Moore); match_count lags the hit by 1 cycle.
// No backpressure: in_valid qualifies bits, bubbles hold state, cfg_load discards its bit.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEF_PATTERN_C,
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = OVL_ON,
  parameter logic               DEF_MOORE   = OUT_MOORE,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               moore_q, moore_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit;

  seq_det_window #(
    .MAX_LEN (MAX_LEN)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .x_i        (x),
    .clear_i    (cfg_load),
    .pattern_i  (pattern_q),
    .len_i      (len_q),
    .overlap_i  (overlap_q),
    .hit_o      (hit)
  );

  // Config next-state: load on cfg_load, clamping over-long lengths to MAX_LEN.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    moore_d   = moore_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      overlap_d = cfg_overlap;
      moore_d   = cfg_moore;
    end
  end

  // Registered hit and saturating counter; clear beats a coincident hit.
  always_comb begin
    z_d   = cfg_load ? 1'b0 : hit;
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Config, Moore output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      moore_q   <= DEF_MOORE;
      z_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      moore_q   <= moore_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
    end
  end

  assign z           = (moore_q == OUT_MOORE) ? z_q : hit;
  assign match_count = cnt_q;

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Successor to the fixed-pattern Mealy/Moore detectors.
- Pattern, length, overlap mode and output timing (Mealy/Moore) are configurable.
- Bits are qualified by in_valid. A saturating match counter is included.
- Sits on a serial input stream and flags pattern occurrences to downstream control logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits, must be ≥2.
- CNT_W, 16: match counter width.
- DEF_PATTERN, 8'b0010_1111: pattern loaded at reset, right-aligned.
- DEF_LEN, 6: pattern length loaded at reset.
- DEF_OVERLAP, 1: overlap mode at reset.
- DEF_MOORE, 1: output mode at reset.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  x is a valid stream bit this cycle.
- x  in  1  serial data bit.
- cfg_load  in  1  load cfg_* fields this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first-received bit, bit [0] the last.
- cfg_len  in  LEN_W=$clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- cfg_moore  in  1  1 = registered (Moore) z, 0 = combinational (Mealy) z.
- cnt_clr  in  1  synchronous clear of match_count.
- z  out  1  match pulse.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset:
  - hist=0, fill=0, z_q=0, match_count=0.
  - Active config = DEF_*.
  - z=0 during and after reset until a hit occurs.
  - Reset mid-pattern discards all partial history.
- Config register (pattern, len, overlap, moore) updates only on cfg_load.
  - len is clamped: cfg_len > MAX_LEN stores MAX_LEN.
  - len == 0 disables detection: hit is never asserted.
  - A cycle with cfg_load: hist and fill cleared, z_q cleared, Mealy z forced 0. A coincident in_valid bit is discarded, neither shifted nor evaluated. match_count is unchanged.
- History:
  - On in_valid (no cfg_load): hist <= {hist[MAX_LEN-2:0], x}.
  - fill increments, saturating at MAX_LEN.
  - Cycles with in_valid=0 leave hist, fill and the pending match state unchanged (bubbles do not break a sequence).
- Hit (combinational), true when all hold:
  - in_valid && !cfg_load && len != 0 && fill >= len-1;
  - the low len bits of {hist, x} equal the low len bits of pattern.
- Overlap mode: fill advances normally after a hit, so trailing bits of a match may start the next one.
- Non-overlap mode: on a hit, fill <= 0. The next match needs len fresh valid bits.
- Output:
  - Mealy: z = hit, same cycle as the final bit.
  - Moore: z_q <= hit; z = z_q. z is high exactly one cycle, the cycle after the final bit, regardless of in_valid in that cycle.
  - Changing mode via cfg_load takes effect from the next cycle.
- Counter:
  - On hit: match_count += 1, saturating at 2^CNT_W-1.
  - cnt_clr has priority: clr with coincident hit gives match_count=0 (that hit is not counted). z still pulses.
- Latency:
  - Mealy: 0 cycles from the final bit to z.
  - Moore: 1 cycle.
  - match_count updates 1 cycle after the hit.

Decomposition:
- Package seq_det_pkg holds:
  - LEN_W computation function;
  - default pattern/length constants;
  - mode encodings OVL_ON/OVL_OFF and OUT_MEALY/OUT_MOORE.
- Sub-module seq_det_window:
  - contains the history shift register, fill counter and masked compare producing hit;
  - takes len/pattern/overlap/clear as inputs.
- Top seq_detector_prog holds the config register, output-mode register and match counter.

Test Plan:
- Defaults (101111, overlap, Moore), in_valid=1, stream 1,0,1,1,1,1,0,1,1,1,1 -> z high exactly the cycles after bit indices 5 and 10; match_count=2.
- cfg_load pattern=4'b1010, len=4, overlap=1, Mealy; stream 1,0,1,0,1,0,1 -> z high same-cycle at indices 3 and 5; count=2. Repeat with overlap=0 -> z only at index 3; count=1.
- Default pattern with in_valid=0 bubbles of 1–3 cycles inserted between every bit of 101111 -> a single z pulse one cycle after the final valid bit. No z during bubbles.
- cfg_load asserted after 10111 has been received, same pattern reloaded, then 1 -> no z. A full 101111 afterwards -> z.
- CNT_W=4: 20 consecutive matches -> match_count saturates at 15. cnt_clr coincident with a hit -> 0, and the z pulse is still present.
- rst pulsed asynchronously after 10111 -> z=0, count=0. A following single 1 gives no z. cfg_len=0 -> no z for any stream. cfg_len=12 with MAX_LEN=8 behaves as len=8.
